// File: rtl/arb_pkg.sv
// Shared definitions for the arbitro_sched scheduler slice.
// Contents:
//   state_t    - scheduler FSM encoding (IDLE, SERVE, STALL)
//   MODE_PRIO  - fixed-priority pop arbitration selector
//   MODE_RR    - burst-limited round-robin pop arbitration selector
//   clog2_f    - ceiling log2, usable in constant expressions
//   onehot32   - 32-bit one-hot decode of an index
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        STALL = 2'b10
    } state_t;

    localparam int MODE_PRIO = 0;
    localparam int MODE_RR   = 1;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] onehot32(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/arbitro_sched_if.sv
// Bundle between the class demultiplexer, the per-class FIFO bank and the
// scheduler.
//   master : the scheduler side (consumes demux word and FIFO status,
//            produces pop/push strobes, registered word, drop and debug)
//   slave  : the environment side (demux + FIFO bank)
// Signals:
//   data_in / data_in_valid       demux word and its qualifier
//   arb_empty / arb_almost_full   per-FIFO status
//   arb_pop / arb_push            one-hot-or-zero strobes
//   data_out / drop               registered word and discard pulse
//   grant_idx / state             current grant and FSM state
interface arbitro_sched_if
    import arb_pkg::*;
#(
    parameter int FIFO_UNITS = 4,
    parameter int WORD_SIZE  = 10
);
    localparam int CLASS_BITS = clog2_f(FIFO_UNITS);

    logic [WORD_SIZE-1:0]  data_in;
    logic                  data_in_valid;
    logic [FIFO_UNITS-1:0] arb_empty;
    logic [FIFO_UNITS-1:0] arb_almost_full;
    logic [FIFO_UNITS-1:0] arb_pop;
    logic [FIFO_UNITS-1:0] arb_push;
    logic [WORD_SIZE-1:0]  data_out;
    logic                  drop;
    logic [CLASS_BITS-1:0] grant_idx;
    logic [1:0]            state;

    modport master (
        input  data_in, data_in_valid, arb_empty, arb_almost_full,
        output arb_pop, arb_push, data_out, drop, grant_idx, state
    );

    modport slave (
        output data_in, data_in_valid, arb_empty, arb_almost_full,
        input  arb_pop, arb_push, data_out, drop, grant_idx, state
    );

endinterface

// File: rtl/rr_next_sel.sv
// Cyclic next-set-bit finder.
// Ports:
//   mask     in  FIFO_UNITS  candidate bits (non-empty FIFOs)
//   start    in  CLASS_BITS  search begins at start+1 and wraps; start
//                            itself is the last candidate examined
//   next_idx out CLASS_BITS  first set index found (start when none)
//   valid    out 1           any mask bit set
// With start = FIFO_UNITS-1 this degenerates to a lowest-index priority
// encoder, which is how the fixed-priority mode reuses it.
module rr_next_sel
    import arb_pkg::*;
#(
    parameter int FIFO_UNITS = 4
) (
    input  logic [FIFO_UNITS-1:0]          mask,
    input  logic [clog2_f(FIFO_UNITS)-1:0] start,
    output logic [clog2_f(FIFO_UNITS)-1:0] next_idx,
    output logic                           valid
);
    localparam int CLASS_BITS = clog2_f(FIFO_UNITS);

    logic [CLASS_BITS-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit wins; the
    // offset FIFO_UNITS wraps to start itself, covering the single-FIFO case.
    always_comb begin
        next_idx = start;
        valid    = 1'b0;
        cand     = start;
        for (int i = FIFO_UNITS; i >= 1; i--) begin
            cand = start + CLASS_BITS'(i);
            if (mask[cand]) begin
                next_idx = cand;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_sched.sv
// Pop/push scheduler between the class demultiplexer and FIFO_UNITS
// per-class FIFOs.
// Ports:
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-low reset
//   bus    master modport of arbitro_sched_if (see interface header)
// Pop side: IDLE/SERVE/STALL FSM with fixed-priority (MODE 0) or
// burst-limited round-robin (MODE 1) grant; any almost_full forces STALL,
// left only after RESUME_DLY consecutive clean cycles.
// Push side: class field of data_in decoded to a registered one-hot push,
// or a drop pulse when the target FIFO is almost full.
module arbitro_sched
    import arb_pkg::*;
#(
    parameter int FIFO_UNITS = 4,
    parameter int WORD_SIZE  = 10,
    parameter int MODE       = 0,
    parameter int BURST      = 4,
    parameter int RESUME_DLY = 2
) (
    input  logic            clk,
    input  logic            reset,
    arbitro_sched_if.master bus
);
    localparam int CLASS_BITS = clog2_f(FIFO_UNITS);
    localparam int BURST_W    = clog2_f(BURST + 1);
    localparam int RES_W      = clog2_f(RESUME_DLY + 1);

    state_t                state_q;
    logic [CLASS_BITS-1:0] grant_q;
    logic [BURST_W-1:0]    burst_q;
    logic [RES_W-1:0]      resume_q;

    logic [FIFO_UNITS-1:0] push_q;
    logic [WORD_SIZE-1:0]  data_q;
    logic                  drop_q;

    logic [CLASS_BITS-1:0] sel_start;
    logic [CLASS_BITS-1:0] sel_idx;
    logic                  sel_valid;
    logic [CLASS_BITS-1:0] idle_grant;
    logic [CLASS_BITS-1:0] serve_grant;
    logic [BURST_W-1:0]    serve_burst;
    logic [FIFO_UNITS-1:0] pop_c;
    logic [CLASS_BITS-1:0] push_cls;
    logic [FIFO_UNITS-1:0] push_dec;

    // Fixed priority searches from the top index so the wrap lands on 0 first.
    assign sel_start = (MODE == MODE_PRIO) ? CLASS_BITS'(FIFO_UNITS - 1) : grant_q;

    rr_next_sel #(
        .FIFO_UNITS (FIFO_UNITS)
    ) u_sel (
        .mask     (~bus.arb_empty),
        .start    (sel_start),
        .next_idx (sel_idx),
        .valid    (sel_valid)
    );

    // Candidate grants. Round-robin holds a non-empty grant until the burst
    // budget is used up; burst_q counts pops already taken beyond the first.
    always_comb begin
        idle_grant  = sel_idx;
        serve_grant = sel_idx;
        serve_burst = '0;
        if (MODE == MODE_RR) begin
            if (!bus.arb_empty[grant_q]) begin
                idle_grant = grant_q;
            end
            if (!bus.arb_empty[grant_q] && (burst_q < BURST_W'(BURST - 1))) begin
                serve_grant = grant_q;
                serve_burst = burst_q + BURST_W'(1);
            end
        end
    end

    // Scheduler FSM. Almost_full pre-empts every other transition; STALL exits
    // on the edge where the clean-cycle count reaches RESUME_DLY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            burst_q  <= '0;
            resume_q <= '0;
        end else if (|bus.arb_almost_full) begin
            state_q  <= STALL;
            resume_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sel_valid) begin
                        state_q <= SERVE;
                        grant_q <= idle_grant;
                        burst_q <= '0;
                    end
                end
                SERVE: begin
                    if (!sel_valid) begin
                        state_q <= IDLE;
                    end else begin
                        grant_q <= serve_grant;
                        burst_q <= serve_burst;
                    end
                end
                STALL: begin
                    if (resume_q == RES_W'(RESUME_DLY - 1)) begin
                        state_q  <= IDLE;
                        resume_q <= '0;
                    end else begin
                        resume_q <= resume_q + RES_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pop is qualified by the live empty flag so an empty FIFO is never popped.
    always_comb begin
        pop_c = '0;
        if (state_q == SERVE) begin
            pop_c[grant_q] = ~bus.arb_empty[grant_q];
        end
    end

    assign push_cls = bus.data_in[WORD_SIZE-1 -: CLASS_BITS];
    assign push_dec = FIFO_UNITS'(onehot32(32'(push_cls)));

    // Push path: an all-zero word is the demux idle pattern and is ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push_q <= '0;
            data_q <= '0;
            drop_q <= 1'b0;
        end else begin
            data_q <= bus.data_in;
            if (bus.data_in_valid && (bus.data_in != '0)) begin
                push_q <= push_dec & ~bus.arb_almost_full;
                drop_q <= bus.arb_almost_full[push_cls];
            end else begin
                push_q <= '0;
                drop_q <= 1'b0;
            end
        end
    end

    assign bus.arb_pop   = pop_c;
    assign bus.arb_push  = push_q;
    assign bus.data_out  = data_q;
    assign bus.drop      = drop_q;
    assign bus.grant_idx = grant_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_arbitro_sched.sv
// Scoreboard bench for arbitro_sched: one fixed-priority and one round-robin
// instance share the same stimulus. The driver predicts each cycle's outputs
// from a behavioural model and queues them; the monitor compares at negedge.
module tb_arbitro_sched;
    import arb_pkg::*;

    localparam int N   = 4;
    localparam int W   = 10;
    localparam int BST = 4;
    localparam int RD  = 2;

    typedef struct {
        logic [N-1:0] pop;
        logic [N-1:0] push;
        logic [W-1:0] data;
        logic         drop;
        logic [1:0]   grant;
        logic [1:0]   state;
    } exp_t;

    logic clk;
    logic reset;

    arbitro_sched_if #(.FIFO_UNITS(N), .WORD_SIZE(W)) bus0 ();
    arbitro_sched_if #(.FIFO_UNITS(N), .WORD_SIZE(W)) bus1 ();

    arbitro_sched #(
        .FIFO_UNITS (N), .WORD_SIZE (W), .MODE (0), .BURST (BST), .RESUME_DLY (RD)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    arbitro_sched #(
        .FIFO_UNITS (N), .WORD_SIZE (W), .MODE (1), .BURST (BST), .RESUME_DLY (RD)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    int errors = 0;
    int checks = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model: phase, grant, pops-in-burst and clean-cycle count.
    state_t m_st[2];
    int     m_g[2];
    int     m_b[2];
    int     m_r[2];
    logic [N-1:0] p_push;
    logic         p_drop;
    logic [W-1:0] p_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lowestReady(input logic [N-1:0] emp);
        for (int i = 0; i < N; i++) begin
            if (!emp[i]) return i;
        end
        return 0;
    endfunction

    function automatic int nextAfter(input int g, input logic [N-1:0] emp);
        for (int off = 1; off <= N; off++) begin
            if (!emp[(g + off) % N]) return (g + off) % N;
        end
        return g;
    endfunction

    // Advance one instance's model across a clock edge; d is also its MODE.
    task automatic modelStep(input int d, input logic rst_n,
                             input logic [N-1:0] emp, input logic [N-1:0] af);
        if (!rst_n) begin
            m_st[d] = IDLE; m_g[d] = 0; m_b[d] = 0; m_r[d] = 0;
        end else if (af != '0) begin
            m_st[d] = STALL; m_r[d] = 0;
        end else begin
            case (m_st[d])
                IDLE: begin
                    if (emp != '1) begin
                        m_st[d] = SERVE;
                        m_b[d]  = 0;
                        if (d == 0) m_g[d] = lowestReady(emp);
                        else if (emp[m_g[d]]) m_g[d] = nextAfter(m_g[d], emp);
                    end
                end
                SERVE: begin
                    if (emp == '1) begin
                        m_st[d] = IDLE;
                    end else if (d == 0) begin
                        m_g[d] = lowestReady(emp);
                    end else if (!emp[m_g[d]] && m_b[d] < BST - 1) begin
                        m_b[d] = m_b[d] + 1;
                    end else begin
                        m_g[d] = nextAfter(m_g[d], emp);
                        m_b[d] = 0;
                    end
                end
                default: begin
                    m_r[d] = m_r[d] + 1;
                    if (m_r[d] == RD) begin
                        m_st[d] = IDLE;
                        m_r[d]  = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic pushModel(input logic rst_n, input logic vld, input logic [W-1:0] din,
                             input logic [N-1:0] af);
        int cls;
        cls = int'(din) / (1 << (W - 2));
        p_push = '0;
        p_drop = 1'b0;
        p_data = rst_n ? din : '0;
        if (rst_n && vld && din != '0) begin
            if (af[cls]) p_drop = 1'b1;
            else         p_push = N'(1 << cls);
        end
    endtask

    // Drive one cycle, queue the expected outputs for it, then advance models.
    task automatic applyStimulus(input logic rst_n, input logic vld, input logic [W-1:0] din,
                                 input logic [N-1:0] emp, input logic [N-1:0] af);
        exp_t e;
        reset = rst_n;
        bus0.data_in = din; bus0.data_in_valid = vld; bus0.arb_empty = emp; bus0.arb_almost_full = af;
        bus1.data_in = din; bus1.data_in_valid = vld; bus1.arb_empty = emp; bus1.arb_almost_full = af;
        for (int d = 0; d < 2; d++) begin
            e.pop   = (m_st[d] == SERVE && !emp[m_g[d]]) ? N'(1 << m_g[d]) : '0;
            e.push  = p_push;
            e.drop  = p_drop;
            e.data  = p_data;
            e.grant = 2'(m_g[d]);
            e.state = m_st[d];
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
            modelStep(d, rst_n, emp, af);
        end
        pushModel(rst_n, vld, din, af);
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    exp_t mon_e;

    // Monitor: every queued prediction is compared against the live outputs.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            mon_e = q0.pop_front();
            checkOutput("pop",   0, 32'(bus0.arb_pop),   32'(mon_e.pop));
            checkOutput("push",  0, 32'(bus0.arb_push),  32'(mon_e.push));
            checkOutput("drop",  0, 32'(bus0.drop),      32'(mon_e.drop));
            checkOutput("data",  0, 32'(bus0.data_out),  32'(mon_e.data));
            checkOutput("grant", 0, 32'(bus0.grant_idx), 32'(mon_e.grant));
            checkOutput("state", 0, 32'(bus0.state),     32'(mon_e.state));
        end
        if (q1.size() > 0) begin
            mon_e = q1.pop_front();
            checkOutput("pop",   1, 32'(bus1.arb_pop),   32'(mon_e.pop));
            checkOutput("push",  1, 32'(bus1.arb_push),  32'(mon_e.push));
            checkOutput("drop",  1, 32'(bus1.drop),      32'(mon_e.drop));
            checkOutput("data",  1, 32'(bus1.data_out),  32'(mon_e.data));
            checkOutput("grant", 1, 32'(bus1.grant_idx), 32'(mon_e.grant));
            checkOutput("state", 1, 32'(bus1.state),     32'(mon_e.state));
        end
    end

    initial begin
        logic [N-1:0] emp;
        logic [N-1:0] af;
        logic         rn;

        // First reset edge establishes a known state; nothing is checked yet.
        reset = 1'b0;
        bus0.data_in = 10'h3FF; bus0.data_in_valid = 1'b1; bus0.arb_empty = '0; bus0.arb_almost_full = '1;
        bus1.data_in = 10'h3FF; bus1.data_in_valid = 1'b1; bus1.arb_empty = '0; bus1.arb_almost_full = '1;
        modelStep(0, 1'b0, '0, '1);
        modelStep(1, 1'b0, '0, '1);
        pushModel(1'b0, 1'b1, 10'h3FF, '1);
        @(posedge clk);
        #2;

        $display("[TB] reset hold");
        applyStimulus(1'b0, 1'b1, 10'h3FF, 4'b0000, 4'b1111);
        applyStimulus(1'b0, 1'b1, 10'h3FF, 4'b0000, 4'b1111);

        $display("[TB] push decode and drop");
        applyStimulus(1'b1, 1'b1, 10'h2A5, 4'b1111, 4'b0000);
        applyStimulus(1'b1, 1'b1, 10'h000, 4'b1111, 4'b0000);
        applyStimulus(1'b1, 1'b1, 10'h001, 4'b1111, 4'b0000);
        applyStimulus(1'b1, 1'b1, 10'h3FF, 4'b1111, 4'b1000);
        repeat (4) applyStimulus(1'b1, 1'b0, 10'h000, 4'b1111, 4'b0000);

        $display("[TB] fixed priority");
        repeat (5) applyStimulus(1'b1, 1'b0, 10'h000, 4'b0101, 4'b0000);
        repeat (3) applyStimulus(1'b1, 1'b0, 10'h000, 4'b1101, 4'b0000);
        repeat (2) applyStimulus(1'b1, 1'b0, 10'h000, 4'b1111, 4'b0000);

        $display("[TB] round robin bursts");
        repeat (14) applyStimulus(1'b1, 1'b0, 10'h000, 4'b0000, 4'b0000);
        repeat (4)  applyStimulus(1'b1, 1'b0, 10'h000, 4'b1011, 4'b0000);

        $display("[TB] stall hysteresis");
        repeat (3) applyStimulus(1'b1, 1'b0, 10'h000, 4'b0000, 4'b0000);
        applyStimulus(1'b1, 1'b0, 10'h000, 4'b0000, 4'b0001);
        repeat (6) applyStimulus(1'b1, 1'b0, 10'h000, 4'b0000, 4'b0000);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            emp = N'($urandom) & N'($urandom);
            af  = ($urandom_range(0, 9) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
            rn  = ($urandom_range(0, 59) != 0);
            applyStimulus(rn, 1'($urandom), ($urandom_range(0, 5) == 0) ? 10'h000 : W'($urandom),
                          emp, af);
        end

        for (int i = 0; i < 5 && (q0.size() > 0 || q1.size() > 0); i++) begin
            @(negedge clk);
        end
        #1;
        checks = checks + 1;
        if (q0.size() > 0 || q1.size() > 0) begin
            errors = errors + 1;
            $display("[TB] FAIL drain: got %0d pending expected 0", q0.size() + q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_sched.md
# arbitro_sched

Parametrised pop/push scheduler between the class demultiplexer and the bank of FIFO_UNITS per-class FIFOs. It supports fixed-priority or burst-limited round-robin pop arbitration, and a hysteretic stall on any almost_full. The push path decodes the class field from the incoming word and presents it as a registered one-hot push with a drop indication. It replaces the combinational 4-FIFO arbitration condition logic with a registered FSM-based scheduler.

## Interface
- FIFO_UNITS, 4, number of FIFOs; power of two, ≥2
- WORD_SIZE, 10, word width; must exceed CLASS_BITS
- MODE, 0, 0 = fixed priority (index 0 highest), 1 = round-robin
- BURST, 4, max consecutive pops from one FIFO in MODE 1; ≥1
- RESUME_DLY, 2, consecutive almost_full-free cycles required to leave STALL; ≥1
- CLASS_BITS, derived $clog2(FIFO_UNITS), local, not overridable

- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- data_in  in  WORD_SIZE  demux word; class = data_in[WORD_SIZE-1 -: CLASS_BITS], payload = remaining low bits
- data_in_valid  in  1  data_in qualifies this cycle
- arb_empty  in  FIFO_UNITS  per-FIFO empty
- arb_almost_full  in  FIFO_UNITS  per-FIFO almost full
- arb_pop  out  FIFO_UNITS  one-hot-or-zero pop
- arb_push  out  FIFO_UNITS  one-hot-or-zero push, registered
- data_out  out  WORD_SIZE  registered copy of data_in, aligned with arb_push
- drop  out  1  one-cycle pulse: word discarded because its target was almost_full
- grant_idx  out  CLASS_BITS  current grant register
- state  out  2  FSM state, debug

## Operation
- FSM states: IDLE, SERVE, STALL. While reset is low at a clock edge: state = IDLE, grant_idx = 0, burst counter = 0, resume counter = 0, arb_push = 0, data_out = 0, drop = 0. arb_pop = 0 because the state is IDLE.
- Transition priority at each edge is STALL entry first, then the rest.
  - Any state → STALL when any arb_almost_full bit is 1; the resume counter clears.
  - STALL: the resume counter increments each cycle with no almost_full and clears on any almost_full. The FSM goes to IDLE when the counter reaches RESUME_DLY.
  - IDLE → SERVE when any FIFO is non-empty. grant_idx loads the selected index on the same edge.
  - SERVE → IDLE when all arb_empty bits are 1.
- Grant selection, evaluated every SERVE/IDLE edge:
  - MODE 0: grant = lowest-index non-empty FIFO.
  - MODE 1: keep the current grant while it is non-empty and burst counter < BURST-1; the burst counter increments per pop. Otherwise move to the next non-empty index cyclically after the current one and clear the burst counter. If it is the only non-empty FIFO, it stays granted and the counter clears.
- arb_pop[g] = (state == SERVE) & (g == grant_idx) & ~arb_empty[g]. This is combinational from registered state, so a pop never occurs on an empty FIFO. It is zero in IDLE and STALL.
- Push path, registered at each edge:
  - Idle word: class = 0 and payload = 0; no push, no drop.
  - Otherwise, if data_in_valid and the word is not idle: arb_push <= onehot(class) & ~arb_almost_full[class], and drop <= arb_almost_full[class].
  - data_out <= data_in unconditionally.
  - Pushes continue in STALL to FIFOs that are not almost full.
- Simultaneous events:
  - Almost_full wins over all other transitions.
  - Empty on the granted FIFO with others non-empty: regrant on the same edge, no IDLE detour.
  - Reset mid-burst discards the grant and counters.

## Timing
- Push latency: 1 cycle from data_in to arb_push, data_out and drop.
- Pop: arb_empty deasserting in IDLE gives arb_pop in the next cycle.
- STALL: pops drop on the cycle after almost_full is sampled. The earliest pop after almost_full clears is RESUME_DLY+2 cycles later: STALL → IDLE → SERVE.
- Each granted index pops at most once per cycle.
- In MODE 1, at most BURST consecutive pops from one FIFO when others are waiting.

## Structure
- Package arb_pkg:
  - state encoding IDLE = 2'b00, SERVE = 2'b01, STALL = 2'b10
  - MODE_PRIO = 0, MODE_RR = 1
  - onehot/clog2 helper functions
- Sub-module rr_next_sel (combinational): inputs mask[FIFO_UNITS] and start[CLASS_BITS]; outputs the next set index cyclically after start, plus a valid flag. It is used for MODE 1, and for MODE 0 with start = FIFO_UNITS-1.
- The top level holds the FSM, counters and push registers.

## Test plan
- Reset hold: reset = 0 for 3 cycles with all inputs active → all outputs 0, state = IDLE, grant_idx = 0.
- Push decode (WORD_SIZE = 10):
  - data_in = 10'h2A5 valid → arb_push = 4'b0100 next cycle, data_out = 10'h2A5.
  - 10'h000 → no push.
  - 10'h001 → arb_push = 4'b0001.
- Drop: arb_almost_full = 4'b1000, data_in = 10'h3FF valid → arb_push = 0, drop = 1 for one cycle, state = STALL.
- Priority (MODE 0): arb_empty = 4'b0101 → arb_pop = 4'b0010 continuously. Setting arb_empty[1] = 1 → arb_pop = 4'b1000 next cycle.
- Round-robin (MODE 1, BURST = 4): all FIFOs non-empty → pops 0,0,0,0,1,1,1,1,2,… With only FIFO 2 non-empty → 2 popped every cycle.
- Stall hysteresis (RESUME_DLY = 2): almost_full pulses 1 cycle mid-SERVE → arb_pop = 0 for 3 cycles, then resumes on the prior grant index (MODE 0).
